muxn_arb: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer and arbiter, the successor to the 4:1 combinational mux. It selects one of CH valid/ready input channels, either by a static select or by round-robin arbitration, and forwards the word through a single output register with a valid/ready handshake. It sits between multiple producer blocks and one shared downstream consumer.

---
 rtl/muxn_arb.sv | 82 ++++++++
 tb/tb_muxn_arb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/muxn_arb.sv
// muxn_arb: CH-way valid/ready mux, fixed select (mode=0) or round-robin (mode=1); MUXN_PARITY_EN adds out_par.
// Latency: one cycle through the output register; one word per cycle while out_ready stays high.
// Backpressure: out_valid && !out_ready holds out_* stable and drops every in_ready.
module muxn_arb #(
   parameter int WIDTH = 8,
   parameter int CH    = 4,
   parameter int SELW  = $clog2(CH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mode,
   input  logic [SELW-1:0]     sel,
   input  logic [CH*WIDTH-1:0] in_data,
   input  logic [CH-1:0]       in_valid,
   output logic [CH-1:0]       in_ready,
   output logic [WIDTH-1:0]    out_data,
   output logic [SELW-1:0]     out_ch,
   output logic                out_valid,
   input  logic                out_ready
`ifdef MUXN_PARITY_EN
   ,
   output logic                out_par
`endif
);

   logic [SELW-1:0]  ptr;
   logic [SELW-1:0]  gnt;
   logic             gnt_vld;
   logic             load;
   logic             xfer;
   logic [WIDTH-1:0] word;

   assign load = !out_valid || out_ready;
   assign xfer = load && gnt_vld && !rst;
   assign word = in_data[gnt*WIDTH +: WIDTH];

   always_comb begin
      gnt     = '0;
      gnt_vld = 1'b0;
      if (!mode) begin
         gnt     = sel;
         gnt_vld = in_valid[sel];
      end else begin
         // Scan backwards from ptr so the nearest valid channel after ptr is the last to assign.
         for (int k = CH; k >= 1; k--) begin
            if (in_valid[ptr + SELW'(k)]) begin
               gnt     = ptr + SELW'(k);
               gnt_vld = 1'b1;
            end
         end
      end
   end

   always_comb begin
      in_ready = '0;
      if (xfer) in_ready[gnt] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         ptr       <= SELW'(CH - 1);
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= word;
         out_ch    <= gnt;
         ptr       <= gnt;
      end else if (load) begin
         out_valid <= 1'b0;
      end
   end

`ifdef MUXN_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       out_par <= 1'b0;
      else if (xfer) out_par <= ^word;
   end
`endif

endmodule

// File: tb/tb_muxn_arb.sv
// Scoreboard bench for muxn_arb: stimulus pushes expected words, a negedge monitor pops and compares.
module tb_muxn_arb;
   localparam int W    = 8;
   localparam int CH   = 4;
   localparam int SELW = 2;

   logic              clk;
   logic              rst;
   logic              mode;
   logic [SELW-1:0]   sel;
   logic [CH*W-1:0]   in_data;
   logic [CH-1:0]     in_valid;
   logic [CH-1:0]     in_ready;
   logic [W-1:0]      out_data;
   logic [SELW-1:0]   out_ch;
   logic              out_valid;
   logic              out_ready;
`ifdef MUXN_PARITY_EN
   logic              out_par;
`endif

   muxn_arb #(.WIDTH(W), .CH(CH)) dut (
      .clk(clk), .rst(rst), .mode(mode), .sel(sel),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
      .out_ready(out_ready)
`ifdef MUXN_PARITY_EN
      , .out_par(out_par)
`endif
   );

   typedef struct {
      logic [W-1:0] d;
      int           ch;
      bit           p;
   } item_t;

   item_t        q[$];
   int           checks   = 0;
   int           failures = 0;
   int           m_ptr;
   bit           m_valid;
   logic [W-1:0] last_d;
   int           last_ch;
   bit           last_p;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference grant: fixed select, or first valid channel walking forward from ptr with wrap.
   function automatic int pick(input bit md, input int s, input logic [CH-1:0] v, input int p);
      if (!md) return v[s] ? s : -1;
      for (int k = 1; k <= CH; k++)
         if (v[(p + k) % CH]) return (p + k) % CH;
      return -1;
   endfunction

   function automatic logic [CH*W-1:0] rand_data();
      logic [CH*W-1:0] r;
      for (int i = 0; i < CH; i++) r[i*W +: W] = W'($urandom);
      return r;
   endfunction

   // Entered and left 2 time units after a rising edge.
   task automatic step(input bit md, input int s, input logic [CH-1:0] v, input bit ordy,
                       input logic [CH*W-1:0] d);
      int              g;
      bit              ld;
      bit              push;
      item_t           it;
      logic [CH-1:0]   er;
      mode      = md;
      sel       = SELW'(s);
      in_valid  = v;
      out_ready = ordy;
      in_data   = d;
      #2;
      ld = !m_valid || ordy;
      g  = pick(md, s, v, m_ptr);
      er = '0;
      if (ld && g >= 0) er[g] = 1'b1;
      chk("in_ready", in_ready, er);
      push = 1'b0;
      if (ld) begin
         if (g >= 0) begin
            it.d    = d[g*W +: W];
            it.ch   = g;
            it.p    = ($countones(it.d) % 2) == 1;
            push    = 1'b1;
            m_ptr   = g;
            m_valid = 1'b1;
         end else begin
            m_valid = 1'b0;
         end
      end
      @(posedge clk);
      if (push) q.push_back(it);
      #2;
   endtask

   task automatic model_reset();
      q.delete();
      m_ptr   = CH - 1;
      m_valid = 1'b0;
      last_d  = '0;
      last_ch = 0;
      last_p  = 1'b0;
   endtask

   // Monitor: compares whatever the output register holds against the scoreboard head.
   initial begin
      item_t h;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (out_valid) begin
               if (q.size() == 0) begin
                  chk("out_valid_no_expected_word", out_valid, 0);
               end else begin
                  chk("out_data", out_data, q[0].d);
                  chk("out_ch", out_ch, q[0].ch);
`ifdef MUXN_PARITY_EN
                  chk("out_par", out_par, q[0].p);
`endif
                  if (out_ready) begin
                     h       = q.pop_front();
                     last_d  = h.d;
                     last_ch = h.ch;
                     last_p  = h.p;
                  end
               end
            end else begin
               chk("idle_with_pending_words", q.size(), 0);
               chk("hold_out_data", out_data, last_d);
               chk("hold_out_ch", out_ch, last_ch);
`ifdef MUXN_PARITY_EN
               chk("hold_out_par", out_par, last_p);
`endif
            end
         end
      end
   end

   initial begin
      logic [CH*W-1:0] d;
      model_reset();
      rst       = 1'b1;
      mode      = 1'b1;
      sel       = '0;
      in_valid  = '1;
      out_ready = 1'b1;
      in_data   = rand_data();
      #1;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_data", out_data, 0);
      chk("reset_out_ch", out_ch, 0);
      chk("reset_in_ready", in_ready, 0);
      @(posedge clk);
      #2;
      rst = 1'b0;

      // Round-robin from reset: 0,1,2,3,0,1,...
      d = {8'h44, 8'h33, 8'h22, 8'h11};
      for (int i = 0; i < 8; i++) step(1, 0, 4'hF, 1, d);

      // Fixed select of channel 2 with all channels valid.
      for (int i = 0; i < 6; i++) step(0, 2, 4'hF, 1, d);

      // Backpressure for three cycles, then consume and refill on one edge.
      for (int i = 0; i < 3; i++) step(1, 0, 4'hF, 0, rand_data());
      for (int i = 0; i < 3; i++) step(1, 0, 4'hF, 1, rand_data());

      // Sparse round-robin: grant 3, then only 1 and 3 valid.
      step(1, 0, 4'b1000, 1, rand_data());
      step(1, 0, 4'b1010, 1, rand_data());
      step(1, 0, 4'b1010, 1, rand_data());

      // Parity patterns on channel 0.
      step(0, 0, 4'b0001, 1, {24'h0, 8'h07});
      step(0, 0, 4'b0001, 1, {24'h0, 8'h03});
      step(0, 0, 4'b0000, 1, '0);

      for (int i = 0; i < 1500; i++)
         step(1'($urandom_range(0, 1)), $urandom_range(0, CH - 1), CH'($urandom),
              $urandom_range(0, 9) < 7, rand_data());

      // Reset while a word is held under backpressure.
      step(0, 1, 4'b0010, 0, rand_data());
      step(0, 1, 4'b0010, 0, rand_data());
      chk("pre_reset_out_valid", out_valid, m_valid);
      mode      = 1'b1;
      in_valid  = '1;
      out_ready = 1'b1;
      rst       = 1'b1;
      #1;
      chk("midreset_out_valid", out_valid, 0);
      chk("midreset_out_data", out_data, 0);
      chk("midreset_out_ch", out_ch, 0);
      chk("midreset_in_ready", in_ready, 0);
`ifdef MUXN_PARITY_EN
      chk("midreset_out_par", out_par, 0);
`endif
      model_reset();
      @(posedge clk);
      #2;
      chk("reset_held_in_ready", in_ready, 0);
      rst = 1'b0;

      for (int i = 0; i < 300; i++)
         step(1'($urandom_range(0, 1)), $urandom_range(0, CH - 1), CH'($urandom),
              $urandom_range(0, 9) < 7, rand_data());

      for (int i = 0; i < 4; i++) step(1, 0, '0, 1, '0);
      @(negedge clk);
      #1;
      chk("drain_out_valid", out_valid, 0);
      chk("drain_scoreboard_empty", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
